// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 UART transmitter among NREQ byte sources.
// Optional WAIT watchdog enabled by defining UART_ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 400,
  localparam int OW     = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  input  logic              tx_done,
  output logic              busy,
  output logic [OW-1:0]     owner,
  output logic              timeout_err
);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_param
    $error("uart_tx_arbiter: NREQ must be 2..8 and TIMEOUT 1..65535");
  end

  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

  state_t            state_reg, state_next;
  logic [NREQ-1:0]   gnt_reg, gnt_next;
  logic              tx_start_reg, tx_start_next;
  logic [7:0]        tx_data_reg, tx_data_next;
  logic [OW-1:0]     owner_reg, owner_next;
  logic [7:0]        req_byte [NREQ];
  logic [OW-1:0]     winner;
  logic              any_req;

`ifdef UART_ARB_TIMEOUT_EN
  logic [15:0]       wait_cnt_reg, wait_cnt_next;
  logic              timeout_err_reg, timeout_err_next;
`endif

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign req_byte[gi] = req_data[8*gi +: 8];
  end

  assign any_req = |req;

  // Scan from farthest to nearest so the last hit is the first requester after owner.
  always_comb begin
    int cand;
    cand   = 0;
    winner = owner_reg;
    for (int k = NREQ; k >= 1; k--) begin
      cand = (int'(owner_reg) + k) % NREQ;
      if (req[cand[OW-1:0]]) winner = cand[OW-1:0];
    end
  end

  always_comb begin
    state_next    = state_reg;
    gnt_next      = '0;
    tx_start_next = 1'b0;
    tx_data_next  = tx_data_reg;
    owner_next    = owner_reg;
`ifdef UART_ARB_TIMEOUT_EN
    wait_cnt_next    = wait_cnt_reg;
    timeout_err_next = 1'b0;
`endif
    unique case (state_reg)
      IDLE: begin
        if (any_req) begin
          gnt_next[winner] = 1'b1;
          tx_data_next     = req_byte[winner];
          owner_next       = winner;
          state_next       = START;
        end
      end
      START: begin
        tx_start_next = 1'b1;
        state_next    = WAIT;
`ifdef UART_ARB_TIMEOUT_EN
        wait_cnt_next = '0;
`endif
      end
      WAIT: begin
        if (tx_done) begin
          state_next = IDLE;
`ifdef UART_ARB_TIMEOUT_EN
        end else if (wait_cnt_reg == 16'(TIMEOUT - 1)) begin
          // Abort; owner is left on the aborted index so the pointer still moves on.
          timeout_err_next = 1'b1;
          state_next       = IDLE;
        end else begin
          wait_cnt_next = wait_cnt_reg + 16'd1;
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      gnt_reg      <= '0;
      tx_start_reg <= 1'b0;
      tx_data_reg  <= 8'h00;
      owner_reg    <= OW'(NREQ - 1);
`ifdef UART_ARB_TIMEOUT_EN
      wait_cnt_reg    <= '0;
      timeout_err_reg <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      gnt_reg      <= gnt_next;
      tx_start_reg <= tx_start_next;
      tx_data_reg  <= tx_data_next;
      owner_reg    <= owner_next;
`ifdef UART_ARB_TIMEOUT_EN
      wait_cnt_reg    <= wait_cnt_next;
      timeout_err_reg <= timeout_err_next;
`endif
    end
  end

  assign gnt      = gnt_reg;
  assign tx_start = tx_start_reg;
  assign tx_data  = tx_data_reg;
  assign owner    = owner_reg;
  assign busy     = (state_reg != IDLE) || tx_busy;

`ifdef UART_ARB_TIMEOUT_EN
  assign timeout_err = timeout_err_reg;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table, corner sequences, random rounds.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        tx_done;
  logic        busy;
  logic [1:0]  owner;
  logic        timeout_err;

  int pass_cnt = 0;
  int total_cnt = 0;
  int model_owner;

  uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(50)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .gnt(gnt),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done),
    .busy(busy), .owner(owner), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  exp_gnt;
    logic [7:0]  exp_byte;
    int          exp_owner;
    int          dly;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One full transaction starting in IDLE at a negedge: grant, start, WAIT, done.
  task automatic txn(input logic [3:0] r, input logic [31:0] d, input logic [3:0] eg,
                     input logic [7:0] eb, input int eo, input int dly, input string tag);
    int n;
    int starts;
    bit busy_ok;
    req = r;
    req_data = d;
    n = 0;
    do begin @(negedge clk); n++; end while (gnt == 4'b0 && n < 50);
    chk({tag, "_gnt"}, 32'(gnt), 32'(eg));
    chk({tag, "_lat"}, n, 1);
    chk({tag, "_data"}, 32'(tx_data), 32'(eb));
    chk({tag, "_owner"}, 32'(owner), eo);
    req = '0;
    @(negedge clk);
    chk({tag, "_start"}, 32'(tx_start), 1);
    chk({tag, "_gnt_pulse"}, 32'(gnt), 0);
    starts = 1;
    busy_ok = 1;
    repeat (dly) begin
      @(negedge clk);
      if (tx_start) starts++;
      if (!busy) busy_ok = 0;
    end
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk({tag, "_one_start"}, starts, 1);
    chk({tag, "_busy_wait"}, 32'(busy_ok), 1);
    $display("txn %s: req=%b gnt=%b data=%02h owner=%0d", tag, r, eg, eb, eo);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int w;
    bit ok;
    logic [3:0]  m;
    logic [31:0] d;

    vecs[0]  = '{4'b1011, 32'hA355A1A0, 4'b0001, 8'hA0, 0, 200};
    vecs[1]  = '{4'b1011, 32'hA355A1A0, 4'b0010, 8'hA1, 1, 200};
    vecs[2]  = '{4'b1011, 32'hA355A1A0, 4'b1000, 8'hA3, 3, 200};
    vecs[3]  = '{4'b1011, 32'hA355A1A0, 4'b0001, 8'hA0, 0, 200};
    vecs[4]  = '{4'b0011, 32'h0000B1B0, 4'b0010, 8'hB1, 1, 3};
    vecs[5]  = '{4'b0011, 32'h0000B1B0, 4'b0001, 8'hB0, 0, 3};
    vecs[6]  = '{4'b0011, 32'h0000B1B0, 4'b0010, 8'hB1, 1, 1};
    vecs[7]  = '{4'b0001, 32'h000000C0, 4'b0001, 8'hC0, 0, 1};
    vecs[8]  = '{4'b1000, 32'hD3000000, 4'b1000, 8'hD3, 3, 2};
    vecs[9]  = '{4'b1111, 32'hE3E2E1E0, 4'b0001, 8'hE0, 0, 2};
    vecs[10] = '{4'b0100, 32'h00190000, 4'b0100, 8'h19, 2, 5};

    rst_n = 1'b0; req = '0; req_data = '0; tx_busy = 1'b0; tx_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_start", 32'(tx_start), 0);
    chk("rst_data", 32'(tx_data), 0);
    chk("rst_owner", 32'(owner), 3);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tmo", 32'(timeout_err), 0);
    rst_n = 1'b1;
    @(negedge clk);
    model_owner = 3;

    // Vector table: round-robin order, fairness, wrap
    for (int i = 0; i < 11; i++) begin
      txn(vecs[i].req, vecs[i].data, vecs[i].exp_gnt, vecs[i].exp_byte,
          vecs[i].exp_owner, vecs[i].dly, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_idle", i), 32'(busy), 0);
      model_owner = vecs[i].exp_owner;
    end

    // tx_busy alone drives busy in IDLE
    tx_busy = 1'b1;
    #1 chk("busy_from_txbusy", 32'(busy), 1);
    tx_busy = 1'b0;

    // Spurious done in IDLE
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk("spur_idle_busy", 32'(busy), 0);
    chk("spur_idle_start", 32'(tx_start), 0);
    @(negedge clk);
    chk("spur_idle_gnt", 32'(gnt), 0);
    $display("seq spurious done in IDLE");

    // Spurious done during START
    req = 4'b0001; req_data = 32'h000000F0;
    @(negedge clk);
    chk("spur_start_gnt", 32'(gnt), 32'h1);
    tx_done = 1'b1; req = '0;
    @(negedge clk);
    tx_done = 1'b0;
    chk("spur_start_start", 32'(tx_start), 1);
    repeat (3) @(negedge clk);
    chk("spur_start_still_wait", 32'(busy), 1);
    chk("spur_start_no_restart", 32'(tx_start), 0);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk("spur_start_end", 32'(busy), 0);
    model_owner = 0;
    $display("seq spurious done in START");

    // Reset while in WAIT
    req = 4'b0010; req_data = 32'h00004400;
    @(negedge clk);
    chk("rstw_gnt", 32'(gnt), 32'h2);
    req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstw_gnt0", 32'(gnt), 0);
    chk("rstw_start0", 32'(tx_start), 0);
    chk("rstw_data0", 32'(tx_data), 0);
    chk("rstw_owner", 32'(owner), 3);
    chk("rstw_busy", 32'(busy), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_owner = 3;
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    ok = 1;
    repeat (5) begin
      @(negedge clk);
      if (tx_start || busy || gnt != 4'b0) ok = 0;
    end
    chk("rstw_stale_done", 32'(ok), 1);
    $display("seq reset in WAIT");
    txn(4'b0100, 32'h00190000, 4'b0100, 8'h19, 2, 200, "single");
    model_owner = 2;

    // Watchdog (or indefinite WAIT when the watchdog is compiled out)
    req = 4'b0001; req_data = 32'h005500AB;
    @(negedge clk);
    chk("tmo_gnt", 32'(gnt), 32'h1);
    req = 4'b0100;
    @(negedge clk);
    chk("tmo_start", 32'(tx_start), 1);
`ifdef UART_ARB_TIMEOUT_EN
    n = 0;
    do begin @(negedge clk); n++; end while (!timeout_err && n < 100);
    chk("tmo_cycles", n, 50);
    chk("tmo_idle", 32'(busy), 0);
`else
    ok = 1;
    repeat (500) begin
      @(negedge clk);
      if (!busy || timeout_err) ok = 0;
    end
    chk("hang_busy", 32'(ok), 1);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
`endif
    @(negedge clk);
    chk("tmo_next_gnt", 32'(gnt), 32'h4);
    chk("tmo_next_data", 32'(tx_data), 32'h55);
    chk("tmo_err_pulse", 32'(timeout_err), 0);
    req = '0;
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    model_owner = 2;
    $display("seq watchdog / hang");

    // Randomized rounds against the rotation model
    for (int i = 0; i < 40; i++) begin
      m = 4'($urandom_range(1, 15));
      d = $urandom;
      w = -1;
      for (int k = 1; k <= NREQ; k++)
        if (w < 0 && m[(model_owner + k) % NREQ]) w = (model_owner + k) % NREQ;
      tx_busy = 1'($urandom_range(0, 1));
      txn(m, d, 4'(1 << w), d[8*w +: 8], w, int'($urandom_range(1, 20)), $sformatf("rnd%0d", i));
      chk($sformatf("rnd%0d_busy", i), 32'(busy), 32'(tx_busy));
      model_owner = w;
    end
    tx_busy = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

- Round-robin arbiter and sequencer that shares one UART transmitter (8N1, same baud tick as the receiver path) among `NREQ` byte-producing requesters.
- Accepts one byte per grant, drives the transmitter start/data handshake and holds ownership until the transmitter reports frame completion.
- Sits between the application-side byte sources and the single TX serializer, mirroring the receiver's `Done`/`dataout` framing on the transmit side.

## Interface

Parameters:

- `NREQ`, 4, number of requesters (2..8); `OW = $clog2(NREQ)`.
- `TIMEOUT`, 400, cycles allowed in WAIT before abort (used only with the configuration macro; 2× one 10-bit frame at 20 clk/bit).

Ports:

- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  NREQ  request bit per requester; held high with stable data until granted.
- `req_data`  in  8*NREQ  packed bytes; requester i at `[8i+7:8i]`.
- `gnt`  out  NREQ  one-hot, one-cycle pulse: byte of requester i accepted.
- `tx_start`  out  1  one-cycle pulse to the transmitter.
- `tx_data`  out  8  registered byte for the transmitter; stable from grant until next grant.
- `tx_busy`  in  1  transmitter busy (status only; sampled for `busy`).
- `tx_done`  in  1  one-cycle pulse at end of stop bit.
- `busy`  out  1  high in any state other than IDLE, or while `tx_busy` is high.
- `owner`  out  OW  index of the current/last granted requester.
- `timeout_err`  out  1  one-cycle pulse on watchdog abort.

## Operation

- States: IDLE, START, WAIT.
- IDLE: if any `req` bit is set, select the winner by searching from `owner+1` upward, with modulo `NREQ` wrap.
  - At the same edge: `gnt[winner]`←1, `tx_data`←`req_data[winner]`, `owner`←winner, state→START.
  - If no `req` bit is set, remain in IDLE.
- START: `tx_start`=1 for this cycle only; state→WAIT.
- WAIT: remain until `tx_done`=1 is sampled; then state→IDLE.
- `tx_done` outside WAIT is ignored; that includes IDLE and START.
- A requester that deasserts `req` before its grant simply loses its place; there is no queue.
- Pointer wrap: with `owner`=NREQ-1, the search starts at 0.

## Timing

- Reset values: state=IDLE, `gnt`=0, `tx_start`=0, `tx_data`=8'h00, `owner`=NREQ-1 (so requester 0 wins first), `timeout_err`=0.
- `busy` is combinational from state and `tx_busy`.
- Latency:
  - `req` seen in IDLE at edge N gives `gnt` and `tx_data` valid in cycle N+1.
  - `tx_start` is high in cycle N+2.
- Turnaround: with `tx_done` sampled at edge M, the next grant can occur at edge M+1. Minimum 3 cycles per byte plus the transmitter frame time.
- The requester may change `req_data` and drop `req` in the cycle after `gnt`.
- Reset mid-operation: all state clears immediately. No `tx_start` is issued after reset release until a new grant occurs. The in-flight frame's later `tx_done` is ignored (IDLE).

## Configuration

- `UART_ARB_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches `TIMEOUT` without `tx_done`: `timeout_err` pulses for one cycle and the state goes to IDLE.
  - `owner` keeps the aborted index, so the pointer still advances.
  - `tx_done` and the timeout coinciding: `tx_done` wins, with no error.
- Not defined: no counter; WAIT waits indefinitely and `timeout_err` is tied to 0.

## Test plan

- Single request: after reset, `req`=4'b0100, byte 8'h19.
  - Expect `gnt`=4'b0100 one cycle later, `tx_data`=8'h19, and `tx_start` one cycle after that.
  - `busy` stays high until `tx_done`, and `owner`=2.
- Simultaneous requests: `req`=4'b1011 held, each with a distinct byte (8'hA0, 8'hA1, 8'hA3); `tx_done` returned 200 cycles after each `tx_start`.
  - Expect grant order 0, 1, 3, then 0 again.
  - `tx_data` matches each requester's byte.
- Fairness: requesters 0 and 1 both hold `req` continuously; expect alternating grants 0, 1, 0, 1.
- Spurious done: pulse `tx_done` in IDLE and in START; expect no state change and no extra `tx_start`.
- Reset in WAIT: assert `rst_n`=0 for 2 cycles while in WAIT.
  - Expect all outputs at reset values immediately and `owner`=NREQ-1.
  - A subsequent stale `tx_done` must be ignored.
- Timeout (macro on, `TIMEOUT`=50): grant without ever returning `tx_done`.
  - Expect `timeout_err` to pulse exactly 50 cycles into WAIT, then IDLE.
  - The next pending requester is granted on the following edge.
  - With the macro off, `busy` must stay high indefinitely.
